insn_loader: RTL and testbench
==============================

INSN_LOADER -- requirements
Module: insn_loader

Interface
REQ-001 Constant INSN_LOAD_TIME, default 4, is the number of bus beats per program load.
REQ-002 Constant INSN_BUS_COUNT, default 4, is the number of instructions per bus beat.
REQ-003 Constant INSN_SIZE, default 16, is the instruction width in bits.
REQ-004 Constant INSN_BUS_RANGE is the range INSN_BUS_COUNT*INSN_SIZE-1:0.
REQ-005 Constant INSN_LOAD_COUNTER_RANGE is sized to hold 0..INSN_LOAD_TIME-1.
REQ-006 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port start, input, 1 bit: load request from the core controller, sampled in IDLE only.
REQ-009 Port abort, input, 1 bit: cancels the load in progress.
REQ-010 Port src_valid, input, 1 bit: the source beat is valid.
REQ-011 Port src_data, input, INSN_BUS_RANGE: the source beat, instruction j in bits (j+1)*INSN_SIZE-1 : j*INSN_SIZE.
REQ-012 Port src_ready, output, 1 bit: the loader accepts a beat this cycle.
REQ-013 Port init_insn_mem, output, 1 bit: write strobe to instruction memory.
REQ-014 Port insn_data, output, INSN_BUS_RANGE: registered beat for instruction memory.
REQ-015 Port insn_load_counter, output, INSN_LOAD_COUNTER_RANGE: beat index of insn_data.
REQ-016 Port busy, output, 1 bit: high in LOAD and DONE.
REQ-017 Port done, output, 1 bit: one-cycle pulse after the last beat is written.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD and DONE.
REQ-019 IDLE SHALL go to LOAD when start=1 and abort=0, with beat counter cnt cleared to 0.
REQ-020 src_ready SHALL be a combinational function: (state==LOAD) & ~abort.
REQ-021 A beat SHALL be accepted on a cycle with src_valid & src_ready.
REQ-022 On acceptance, the next cycle SHALL show init_insn_mem=1, insn_data=src_data and insn_load_counter=cnt (latency 1).
REQ-023 On acceptance, cnt SHALL increment.
REQ-024 init_insn_mem SHALL be 0 in every cycle that does not follow an acceptance; gaps with src_valid=0 are legal.
REQ-025 insn_data and insn_load_counter SHALL hold their values when init_insn_mem=0.
REQ-026 Acceptance with cnt==INSN_LOAD_TIME-1 SHALL move LOAD to DONE; cnt SHALL not wrap within a load.
REQ-027 DONE SHALL last exactly one cycle, coinciding with the final init_insn_mem pulse, with done=1, then go to IDLE.
REQ-028 start in LOAD or DONE SHALL be ignored, not queued.
REQ-029 abort in LOAD SHALL return the FSM to IDLE next cycle with no beat accepted, no done, and cnt cleared.
REQ-030 abort in IDLE or DONE SHALL have no effect; start with abort in IDLE SHALL stay in IDLE.
REQ-031 A partially loaded memory after abort is permitted; the controller SHALL restart from beat 0.

Reset
REQ-032 Reset SHALL asynchronously force state=IDLE, cnt=0, init_insn_mem=0, insn_data=0, insn_load_counter=0, done=0 and busy=0.
REQ-033 Reset mid-load SHALL discard the load; the first start after reset release SHALL begin at beat 0.

Structure
REQ-034 The INSN_* constants and FSM state encodings (2 bits: IDLE=0, LOAD=1, DONE=2) SHALL live in the shared core definitions include.
REQ-035 The block SHALL be a single module with no sub-module; the output register and cnt SHALL be inline.

Verification
REQ-036 Reset, then start, then 4 back-to-back valid beats 0x1111..0x4444 -> init_insn_mem high for 4 consecutive cycles with counters 0,1,2,3, done high on the 4th, busy low the next cycle.
REQ-037 Valid toggling 1,0,1,0 -> strobes only after accepted beats; insn_data holds between strobes; done after the 4th accept.
REQ-038 abort after 2 beats -> src_ready drops the same cycle; no done; the next start shows counter 0 on the first strobe.
REQ-039 start pulsed during LOAD and DONE -> no effect; exactly 4 strobes and 1 done.
REQ-040 Reset asserted async after beat 1 -> all outputs 0 immediately (before the next clk edge); a new load completes normally.
REQ-041 start with abort in IDLE -> stays IDLE, src_ready=0, busy=0.

Source files
------------

// File: rtl/insn_loader_pkg.sv
// Shared constants and state encodings for the instruction-memory loader.
package insn_loader_pkg;

    localparam int INSN_LOAD_TIME = 4;
    localparam int INSN_BUS_COUNT = 4;
    localparam int INSN_SIZE      = 16;
    localparam int INSN_BUS_W     = INSN_BUS_COUNT * INSN_SIZE;
    localparam int INSN_CNT_W     = (INSN_LOAD_TIME > 1) ? $clog2(INSN_LOAD_TIME) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/insn_loader.sv
// Streams INSN_LOAD_TIME source beats into instruction memory, one write strobe
// per accepted beat, with abort and a one-cycle done pulse on the final beat.
//
// state | meaning
// IDLE  | waiting for start (ignored while abort is high)
// LOAD  | accepting beats; cnt is the index of the next beat
// DONE  | final beat being written; done pulses, then back to IDLE
module insn_loader
    import insn_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  src_valid,
    input  logic [INSN_BUS_W-1:0] src_data,
    output logic                  src_ready,
    output logic                  init_insn_mem,
    output logic [INSN_BUS_W-1:0] insn_data,
    output logic [INSN_CNT_W-1:0] insn_load_counter,
    output logic                  busy,
    output logic                  done
);

    localparam logic [INSN_CNT_W-1:0] LAST_CNT = INSN_CNT_W'(INSN_LOAD_TIME - 1);

    loader_state_t         state_q;
    logic [INSN_CNT_W-1:0] cnt_q;
    logic                  accept;

    assign src_ready = (state_q == ST_LOAD) & ~abort;
    assign accept    = src_valid & src_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            cnt_q             <= '0;
            init_insn_mem     <= 1'b0;
            insn_data         <= '0;
            insn_load_counter <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            init_insn_mem <= accept;
            done          <= 1'b0;
            if (accept) begin
                insn_data         <= src_data;
                insn_load_counter <= cnt_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy    <= 1'b0;
                    end else if (accept) begin
                        // Last beat: leave cnt at 0 rather than letting it wrap.
                        if (cnt_q == LAST_CNT) begin
                            state_q <= ST_DONE;
                            cnt_q   <= '0;
                            done    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + INSN_CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_insn_loader.sv
// Scenario bench for insn_loader: a reference model pushes accepted beats into
// a scoreboard that a monitor pops on every write strobe.
module tb_insn_loader;
    import insn_loader_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic                  abort;
    logic                  src_valid;
    logic [INSN_BUS_W-1:0] src_data;
    logic                  src_ready;
    logic                  init_insn_mem;
    logic [INSN_BUS_W-1:0] insn_data;
    logic [INSN_CNT_W-1:0] insn_load_counter;
    logic                  busy;
    logic                  done;

    insn_loader dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .src_valid         (src_valid),
        .src_data          (src_data),
        .src_ready         (src_ready),
        .init_insn_mem     (init_insn_mem),
        .insn_data         (insn_data),
        .insn_load_counter (insn_load_counter),
        .busy              (busy),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_strobe = 0;
    int n_done   = 0;
    bit mon_en   = 1'b0;

    // model state: 0 idle, 1 load, 2 done
    int   m_state = 0;
    int   m_cnt   = 0;
    logic exp_strobe = 1'b0;
    logic exp_done   = 1'b0;
    logic exp_busy   = 1'b0;
    logic [INSN_CNT_W+INSN_BUS_W-1:0] sb_q[$];

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;

    // Drive one clock of stimulus from a negedge, advance the model, return at next negedge.
    task automatic cycle(input logic st, input logic ab, input logic v, input logic [63:0] d);
        logic acc;
        start     = st;
        abort     = ab;
        src_valid = v;
        src_data  = d;
        acc       = v && (m_state == 1) && !ab;
        exp_strobe = acc;
        exp_done   = 1'b0;
        case (m_state)
            0: if (st && !ab) begin m_state = 1; m_cnt = 0; end
            1: begin
                if (ab) begin
                    m_state = 0; m_cnt = 0;
                end else if (acc) begin
                    sb_q.push_back({INSN_CNT_W'(m_cnt), d});
                    if (m_cnt == INSN_LOAD_TIME - 1) begin
                        m_state = 2; m_cnt = 0; exp_done = 1'b1;
                    end else begin
                        m_cnt++;
                    end
                end
            end
            default: m_state = 0;
        endcase
        exp_busy = (m_state != 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; sb_q.delete();
        exp_strobe = 1'b0; exp_done = 1'b0; exp_busy = 1'b0;
        start = 1'b0; abort = 1'b0; src_valid = 1'b0; src_data = '0;
    endtask

    always @(posedge clk) begin
        logic [INSN_CNT_W+INSN_BUS_W-1:0] e;
        #1;
        if (mon_en) begin
            n_checks++;
            if (init_insn_mem !== exp_strobe)
                $display("FAIL strobe t=%0t got %b want %b", $time, init_insn_mem, exp_strobe);
            else n_pass++;
            if (init_insn_mem === 1'b1) begin
                n_strobe++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_empty t=%0t got strobe with no expected beat", $time);
                end else begin
                    e = sb_q.pop_front();
                    if (insn_data !== e[INSN_BUS_W-1:0] || insn_load_counter !== e[INSN_CNT_W+INSN_BUS_W-1:INSN_BUS_W])
                        $display("FAIL beat t=%0t got %h/%0d want %h/%0d", $time, insn_data, insn_load_counter,
                                 e[INSN_BUS_W-1:0], e[INSN_CNT_W+INSN_BUS_W-1:INSN_BUS_W]);
                    else n_pass++;
                end
            end
            if (done === 1'b1) n_done++;
            n_checks++;
            if (done !== exp_done) $display("FAIL done t=%0t got %b want %b", $time, done, exp_done);
            else n_pass++;
            n_checks++;
            if (busy !== exp_busy) $display("FAIL busy t=%0t got %b want %b", $time, busy, exp_busy);
            else n_pass++;
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        #2;
        n_checks++;
        if ({init_insn_mem, done, busy, src_ready} !== 4'b0000 || insn_data !== '0 || insn_load_counter !== '0)
            $display("FAIL reset_outputs got strb=%b done=%b busy=%b rdy=%b data=%h cnt=%0d want all 0",
                     init_insn_mem, done, busy, src_ready, insn_data, insn_load_counter);
        else n_pass++;
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int s0, d0;
        s0 = n_strobe; d0 = n_done;
        cycle(1, 0, 0, '0);
        src_valid = 1'b1;
        #1;
        n_checks++;
        if (src_ready !== 1'b1) $display("FAIL b2b_ready got %b want 1", src_ready);
        else n_pass++;
        cycle(0, 0, 1, B1);
        cycle(0, 0, 1, B2);
        cycle(0, 0, 1, B3);
        cycle(0, 0, 1, B4);
        cycle(0, 0, 0, '0);
        n_checks++;
        if (n_strobe - s0 !== 4 || n_done - d0 !== 1)
            $display("FAIL b2b_counts got strobes=%0d dones=%0d want 4/1", n_strobe - s0, n_done - d0);
        else n_pass++;
    endtask

    task automatic test_valid_toggle();
        int d0;
        d0 = n_done;
        cycle(1, 0, 0, '0);
        cycle(0, 0, 1, B2);
        cycle(0, 0, 0, B4);
        cycle(0, 0, 0, B4);
        n_checks++;
        if (insn_data !== B2 || insn_load_counter !== 0)
            $display("FAIL toggle_hold got %h/%0d want %h/0", insn_data, insn_load_counter, B2);
        else n_pass++;
        cycle(0, 0, 1, B3);
        cycle(0, 0, 0, B1);
        cycle(0, 0, 1, B1);
        cycle(0, 0, 0, B2);
        n_checks++;
        if (insn_data !== B1 || insn_load_counter !== 2)
            $display("FAIL toggle_hold2 got %h/%0d want %h/2", insn_data, insn_load_counter, B1);
        else n_pass++;
        cycle(0, 0, 1, B4);
        cycle(0, 0, 0, '0);
        n_checks++;
        if (n_done - d0 !== 1) $display("FAIL toggle_done got %0d want 1", n_done - d0);
        else n_pass++;
    endtask

    task automatic test_abort();
        int d0;
        d0 = n_done;
        cycle(1, 0, 0, '0);
        cycle(0, 0, 1, B3);
        cycle(0, 0, 1, B4);
        src_valid = 1'b1;
        abort     = 1'b1;
        #1;
        n_checks++;
        if (src_ready !== 1'b0) $display("FAIL abort_ready got %b want 0", src_ready);
        else n_pass++;
        cycle(0, 1, 1, B1);
        cycle(0, 0, 1, B1);
        cycle(0, 0, 0, '0);
        n_checks++;
        if (n_done - d0 !== 0) $display("FAIL abort_nodone got %0d want 0", n_done - d0);
        else n_pass++;
        cycle(1, 0, 0, '0);
        cycle(0, 0, 1, B2);
        n_checks++;
        if (insn_load_counter !== 0 || init_insn_mem !== 1'b1)
            $display("FAIL abort_restart got cnt=%0d strb=%b want 0/1", insn_load_counter, init_insn_mem);
        else n_pass++;
        cycle(0, 0, 1, B3);
        cycle(0, 0, 1, B4);
        cycle(0, 0, 1, B1);
        cycle(0, 0, 0, '0);
    endtask

    task automatic test_start_ignored();
        int s0, d0;
        s0 = n_strobe; d0 = n_done;
        cycle(1, 0, 0, '0);
        cycle(1, 0, 1, B4);
        cycle(1, 0, 1, B3);
        cycle(1, 0, 0, '0);
        cycle(1, 0, 1, B2);
        cycle(1, 0, 1, B1);
        cycle(1, 0, 0, '0);
        cycle(0, 0, 1, B1);
        cycle(0, 0, 0, '0);
        n_checks++;
        if (n_strobe - s0 !== 4 || n_done - d0 !== 1)
            $display("FAIL start_ignored got strobes=%0d dones=%0d want 4/1", n_strobe - s0, n_done - d0);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int d0;
        cycle(1, 0, 0, '0);
        cycle(0, 0, 1, B1);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({init_insn_mem, done, busy, src_ready} !== 4'b0000 || insn_data !== '0 || insn_load_counter !== '0)
            $display("FAIL async_reset got strb=%b done=%b busy=%b rdy=%b data=%h cnt=%0d want all 0",
                     init_insn_mem, done, busy, src_ready, insn_data, insn_load_counter);
        else n_pass++;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        d0 = n_done;
        cycle(1, 0, 0, '0);
        cycle(0, 0, 1, B3);
        n_checks++;
        if (insn_load_counter !== 0 || insn_data !== B3)
            $display("FAIL async_restart got %h/%0d want %h/0", insn_data, insn_load_counter, B3);
        else n_pass++;
        cycle(0, 0, 1, B4);
        cycle(0, 0, 1, B1);
        cycle(0, 0, 1, B2);
        cycle(0, 0, 0, '0);
        n_checks++;
        if (n_done - d0 !== 1) $display("FAIL async_done got %0d want 1", n_done - d0);
        else n_pass++;
    endtask

    task automatic test_abort_idle();
        cycle(1, 1, 1, B1);
        cycle(0, 0, 1, B2);
        n_checks++;
        if (src_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_idle got rdy=%b busy=%b want 0/0", src_ready, busy);
        else n_pass++;
        cycle(0, 0, 0, '0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_valid_toggle();
        test_abort();
        test_start_ignored();
        test_async_reset();
        test_abort_idle();
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL sb_leftover got %0d want 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
